// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg : shared constants and loader state encoding for the RAM write side
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage : ram_pkg

`default_nettype wire

// File: rtl/ram_addr_gen.sv
// ---------------------------------------------------------------------------
// ram_addr_gen : loadable incrementing address counter with terminal flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_term,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= r_addr + c_one;
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = (r_addr == i_term);

endmodule : ram_addr_gen

`default_nettype wire

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader : stream loader and range clear for the 8-bit x 64K RAM write port
// Optional: CHECKSUM_EN adds a running modulo-256 checksum of loaded bytes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_loader #(
  parameter int                     ADDR_W     = ram_pkg::ADDR_W,
  parameter int                     DATA_W     = ram_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]      CLEAR_LAST = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_clear,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  output logic              busy,
  output logic              done,
  output logic              wrap_err,
  output logic [ADDR_W:0]   count
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  import ram_pkg::*;

  localparam logic [ADDR_W:0]   c_count_one = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_addr_max  = {ADDR_W{1'b1}};

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_done;
  logic               r_wrap;
  logic [ADDR_W:0]    r_count;
  logic               w_accept;
  logic               w_ag_load;
  logic [ADDR_W-1:0]  w_ag_load_val;
  logic               w_ag_inc;
  logic [ADDR_W-1:0]  w_ag_term;
  logic [ADDR_W-1:0]  w_ag_addr;
  logic               w_ag_tc;

  // One counter serves as the clear sweep address and as the load pointer.
  ram_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_ag_load),
    .i_load_val (w_ag_load_val),
    .i_inc      (w_ag_inc),
    .i_term     (w_ag_term),
    .o_addr     (w_ag_addr),
    .o_tc       (w_ag_tc)
  );

  assign in_ready  = (r_state == LOAD);
  assign w_accept  = in_valid && in_ready;
  assign w_ag_term = (r_state == CLEAR) ? CLEAR_LAST : c_addr_max;

  always_comb begin
    w_next        = r_state;
    w_ag_load     = 1'b0;
    w_ag_load_val = '0;
    w_ag_inc      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_clear) begin
          w_next    = CLEAR;
          w_ag_load = 1'b1;
        end else if (load_start) begin
          w_next        = LOAD;
          w_ag_load     = 1'b1;
          w_ag_load_val = load_base;
        end
      end
      CLEAR: begin
        w_ag_inc = 1'b1;
        if (w_ag_tc) w_next = FIN;
      end
      LOAD: begin
        if (w_accept) begin
          w_ag_inc = 1'b1;
          // Stop at the top address rather than let the next write wrap to 0.
          if (in_last || w_ag_tc) w_next = FIN;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == FIN);
      r_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!start_clear && load_start) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
          end
        end
        CLEAR: begin
          r_we   <= 1'b1;
          r_addr <= w_ag_addr;
          r_data <= '0;
        end
        LOAD: begin
          if (w_accept) begin
            r_we    <= 1'b1;
            r_addr  <= w_ag_addr;
            r_data  <= in_data;
            r_count <= r_count + c_count_one;
            if (!in_last && w_ag_tc) r_wrap <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (r_state == IDLE && !start_clear && load_start) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + in_data;
    end
  end

  assign checksum = r_sum;
`endif

  assign mem_we      = r_we;
  assign mem_address = r_addr;
  assign mem_datain  = r_data;
  assign done        = r_done;
  assign wrap_err    = r_wrap;
  assign count       = r_count;
  assign busy        = (r_state == CLEAR) || (r_state == LOAD);

endmodule : ram_loader

`default_nettype wire

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader : randomized self-checking bench for ram_loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_loader;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk;
  logic          reset_n;
  logic          start_clear;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain;
  logic          busy;
  logic          done;
  logic          wrap_err;
  logic [AW:0]   count;
`ifdef CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_loader #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_LAST(16'h000F)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_clear (start_clear),
    .load_start  (load_start),
    .load_base   (load_base),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_datain  (mem_datain),
    .busy        (busy),
    .done        (done),
    .wrap_err    (wrap_err),
    .count       (count)
`ifdef CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [23:0] wr_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  stim[$];
  int          done_cnt;
  bit          ready_seen;
  bit          mon_en;
  int          last_count;
  bit          last_wrap;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) wr_q.push_back({mem_address, mem_datain});
      if (done) done_cnt++;
      if (in_ready) ready_seen = 1'b1;
    end
  end

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, "_wr"}, wr_q[i], exp_q[i]);
    check({tag, "_done"}, done_cnt, 1);
  endtask

  // vmode: 0 valid held high, 1 toggling, 2 random
  task automatic do_load(input string tag, input logic [AW-1:0] base, input bit use_last,
                         input int vmode);
    logic [AW-1:0] a;
    int            exp_cnt;
    bit            exp_wrap;
    logic [7:0]    exp_sum;
    int            idx;
    int            cyc;
    bit            finished;
    bit            acc;
    int            n;
    n        = stim.size();
    exp_q.delete();
    a        = base;
    exp_cnt  = 0;
    exp_wrap = 1'b0;
    exp_sum  = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, stim[i]});
      exp_cnt++;
      exp_sum = exp_sum + stim[i];
      if (use_last && i == n - 1) break;
      if (a == 16'hFFFF) begin
        exp_wrap = 1'b1;
        break;
      end
      a = a + 16'd1;
    end

    wr_q.delete();
    done_cnt   = 0;
    ready_seen = 1'b0;
    mon_en     = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b1;
    load_base  = base;
    @(posedge clk); #1;
    load_start = 1'b0;
    idx      = 0;
    cyc      = 0;
    finished = 1'b0;
    while (!finished && cyc < 300) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      if (idx >= n) in_valid = 1'b0;
      in_data = (idx < n) ? stim[idx] : 8'h00;
      in_last = use_last && (idx == n - 1);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (done) finished = 1'b1;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_timeout"}, 32'(finished), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    compare_writes(tag);
    check({tag, "_accepted"}, idx, exp_cnt);
    check({tag, "_count"}, 32'(count), exp_cnt);
    check({tag, "_wrap"}, 32'(wrap_err), 32'(exp_wrap));
    check({tag, "_idle"}, {busy, in_ready}, 2'b00);
`ifdef CHECKSUM_EN
    check({tag, "_csum"}, 32'(checksum), 32'(exp_sum));
`endif
    last_count = exp_cnt;
    last_wrap  = exp_wrap;
  endtask

  task automatic set_stream_12();
    logic [7:0] v[12];
    v = '{8'h00, 8'h01, 8'h82, 8'h01, 8'h02, 8'h83, 8'h02, 8'h03, 8'h84, 8'h03, 8'h04, 8'h85};
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(v[i]);
  endtask

  initial begin
    int  cyc;
    bit  hit;
    logic [AW-1:0] rb;
    reset_n     = 1'b0;
    start_clear = 1'b0;
    load_start  = 1'b0;
    load_base   = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    mon_en      = 1'b0;
    #1;
    check("rst_outs", {mem_we, mem_address, mem_datain, done, wrap_err, busy, in_ready}, '0);
    check("rst_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    set_stream_12();
    do_load("hold", 16'h0000, 1'b1, 0);
    do_load("toggle", 16'h0000, 1'b1, 1);

    stim.delete();
    stim.push_back(8'hAA); stim.push_back(8'hBB); stim.push_back(8'hCC);
    do_load("wrap", 16'hFFFE, 1'b0, 0);

    // Clear and load requested together: clear wins, load is dropped.
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({16'(i), 8'h00});
    wr_q.delete();
    done_cnt   = 0;
    ready_seen = 1'b0;
    mon_en     = 1'b1;
    @(posedge clk); #1;
    start_clear = 1'b1;
    load_start  = 1'b1;
    load_base   = 16'h1234;
    @(posedge clk); #1;
    start_clear = 1'b0;
    load_start  = 1'b0;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < 100) begin
      @(negedge clk);
      if (done) hit = 1'b1;
      cyc++;
    end
    check("clr_timeout", 32'(hit), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    compare_writes("clr");
    check("clr_ready", 32'(ready_seen), 32'd0);
    check("clr_count_hold", 32'(count), 32'(last_count));
    check("clr_wrap_hold", 32'(wrap_err), 32'(last_wrap));

    // Reset in the middle of a clear sweep.
    @(posedge clk); #1;
    start_clear = 1'b1;
    @(posedge clk); #1;
    start_clear = 1'b0;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < 50) begin
      @(negedge clk);
      if (mem_we && mem_address == 16'h0005) hit = 1'b1;
      cyc++;
    end
    check("rstmid_reach5", 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_outs", {mem_we, mem_address, mem_datain, done, wrap_err, busy, in_ready}, '0);
    check("rstmid_count", 32'(count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wr_q.delete();
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("rstmid_quiet", wr_q.size(), 0);

    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(8'($urandom));
    do_load("after_rst", 16'h0010, 1'b1, 0);

    stim.delete();
    stim.push_back(8'hFF); stim.push_back(8'h02);
    do_load("csum", 16'h0100, 1'b1, 0);

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 20);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      if (t % 3 == 2) rb = 16'hFFFF - 16'($urandom_range(0, 6));
      else            rb = 16'($urandom);
      do_load("rand", rb, 1'b1, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_ram_loader

`default_nettype wire

// File: doc/ram_loader.md
Name: ram_loader

Overview:
Write-side initiator for the 8-bit x 64K program/data RAM. It accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive RAM addresses starting at a programmable base. It also runs a sequenced clear that zeroes a RAM address range at one write per cycle. It sits between the host/boot interface and the RAM write port, so the RAM read path stays purely combinational.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, RAM data width
CLEAR_LAST, 16'hFFFF, last address zeroed by a clear sequence; the sequence starts at 0

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start_clear  in  1  single-cycle request to run the clear sequence
load_start  in  1  single-cycle request to begin a stream load
load_base  in  ADDR_W  first write address for a load, sampled with load_start
in_valid  in  1  stream byte valid
in_data  in  DATA_W  stream byte
in_last  in  1  marks the final byte of the stream
in_ready  out  1  loader can accept a byte
mem_we  out  1  RAM write enable
mem_address  out  ADDR_W  RAM write address
mem_datain  out  DATA_W  RAM write data
busy  out  1  high in CLEAR or LOAD
done  out  1  one-cycle completion pulse
wrap_err  out  1  sticky flag: load ran past address 2^ADDR_W-1
count  out  ADDR_W+1  bytes written by the last or current load

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE.
  - mem_we=0, mem_address=0, mem_datain=0, done=0, wrap_err=0, count=0, busy=0, in_ready=0.
  - Reset mid-operation abandons the sequence; no further writes occur.
- FSM has four states: IDLE, CLEAR, LOAD, FIN.
- IDLE:
  - start_clear moves to CLEAR.
  - Otherwise load_start moves to LOAD, latches ptr=load_base, clears count and wrap_err.
  - If both are asserted in the same cycle, clear wins and load_start is dropped.
  - start_clear and load_start are ignored in every state except IDLE.
- CLEAR:
  - The cycle after entry: mem_we=1, mem_address=0, mem_datain=0.
  - mem_address increments by 1 each cycle.
  - After the write to CLEAR_LAST, go to FIN. The write count is exactly CLEAR_LAST+1.
- LOAD:
  - in_ready = (state==LOAD), decoded combinationally from the state register.
  - A byte is accepted on a rising edge with in_valid && in_ready.
  - The write is registered: in the next cycle mem_we=1, mem_address=ptr, mem_datain=in_data.
  - Also on acceptance: ptr increments, wrapping modulo 2^ADDR_W, and count increments.
  - Write latency is 1 cycle after acceptance. Back-to-back bytes sustain 1 write per cycle.
  - With no acceptance, mem_we=0 and mem_address/mem_datain hold their values.
  - Accepting a byte with in_last=1 goes to FIN.
  - Accepting a byte with in_last=0 while ptr==2^ADDR_W-1: the byte is written, wrap_err is set, and the state goes to FIN. No write wraps to address 0.
- FIN:
  - done=1 for exactly one cycle (the cycle the final write is presented), then IDLE.
  - in_ready=0.
- busy=1 in CLEAR and LOAD only.
- wrap_err and count hold until the next load_start.

Optional Feature:
- CHECKSUM_EN defined:
  - Adds output checksum [DATA_W-1:0], the modulo-2^DATA_W sum of all bytes accepted in the current load.
  - checksum clears on load_start and is unaffected by clear.
  - checksum is reset to 0.
- CHECKSUM_EN undefined: no checksum port and no adder. All other behaviour is identical.

Decomposition:
- Shared package ram_pkg holds:
  - ADDR_W and DATA_W constants and RAM_DEPTH = 2^ADDR_W.
  - The loader state enum {IDLE, CLEAR, LOAD, FIN}, 2 bits.
- One natural sub-module, ram_addr_gen: a loadable, incrementing address counter with a terminal-count flag, shared by the CLEAR and LOAD paths.

Test Plan:
- Load at base 0x0000 with the 12 bytes 00 01 82 01 02 83 02 03 84 03 04 85, in_last on the last byte, in_valid held high. Expect:
  - 12 consecutive mem_we cycles at addresses 0x0000–0x000B with matching data.
  - done pulses once, count=12, wrap_err=0.
- Same stream with in_valid toggling 1/0. Expect:
  - Writes only in cycles following acceptances, with no duplicates.
  - Correct address order and count=12.
- Load base 0xFFFE with bytes AA BB CC and no in_last. Expect:
  - Writes at 0xFFFE and 0xFFFF; CC is never accepted.
  - wrap_err=1, done pulse, count=2, no write at 0x0000.
- start_clear and load_start together in IDLE, with CLEAR_LAST=16'h000F. Expect:
  - 16 writes of 0x00 at addresses 0x0000–0x000F, then done.
  - The load never starts and in_ready stays 0.
- Deassert reset_n during a clear, at address 0x0005. Expect:
  - All outputs 0 immediately and state IDLE.
  - A subsequent load at base 0x0010 works normally.
- CHECKSUM_EN: load bytes FF 02 with in_last on the second. Expect checksum=0x01.
